enigma_conflict_tracker: RTL and testbench

//   Downstream stage of the enigma buffer: consumes port C (valid/ready, 128b payload, 6b id, 2b qos).

---
 rtl/enigma_conflict_tracker_if.sv | 37 +++
 rtl/enigma_conflict_tracker.sv | 128 ++++++++++++
 tb/tb_enigma_conflict_tracker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_conflict_tracker_if.sv
// Port bundle for the enigma conflict tracker: buffer-side port C, execution
// port (m_*), completion strobe (cpl_*), release pulse and status.
// slave = tracker view, master = environment (buffer + execution unit) view.
interface enigma_conflict_tracker_if #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 6
);
  logic              valid_c;
  logic [DATA_W-1:0] payload_c;
  logic [ID_W-1:0]   id_c;
  logic [1:0]        qos_c;
  logic              ready_c;
  logic              conflict_c;
  logic              release_c;
  logic [ID_W-1:0]   releaseid_c;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_payload;
  logic [ID_W-1:0]   m_id;
  logic [1:0]        m_qos;
  logic              cpl_valid;
  logic [ID_W-1:0]   cpl_id;
  logic [ID_W:0]     outstanding;
  logic              err_spurious;

  modport slave (
    input  valid_c, payload_c, id_c, qos_c, m_ready, cpl_valid, cpl_id,
    output ready_c, conflict_c, release_c, releaseid_c,
           m_valid, m_payload, m_id, m_qos, outstanding, err_spurious
  );

  modport master (
    output valid_c, payload_c, id_c, qos_c, m_ready, cpl_valid, cpl_id,
    input  ready_c, conflict_c, release_c, releaseid_c,
           m_valid, m_payload, m_id, m_qos, outstanding, err_spurious
  );
endinterface

// File: rtl/enigma_conflict_tracker.sv
// Outstanding-ID tracker downstream of the enigma buffer.
// A busy bit per ID blocks re-issue of an in-flight ID (conflict_c), accepted
// beats go through an in-order FIFO to the execution port, and completions
// clear the busy bit and come back as a registered one-cycle release pulse.
// ready_c depends only on registered state (FIFO occupancy and credit).
module enigma_conflict_tracker #(
  parameter int DATA_W  = 128,
  parameter int ID_W    = 6,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  enigma_conflict_tracker_if.slave bus
);
  localparam int            PW        = $clog2(DEPTH);
  localparam int            NID       = 1 << ID_W;
  localparam logic [ID_W:0] MAX_OUT_V = (ID_W+1)'(MAX_OUT);
  localparam logic [ID_W:0] CNT_ONE   = (ID_W+1)'(1);
  localparam logic [PW:0]   PTR_ONE   = (PW+1)'(1);

  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [ID_W-1:0]   id;
    logic [1:0]        qos;
  } beat_t;

  beat_t           r_mem [DEPTH];
  logic [PW:0]     r_wptr;
  logic [PW:0]     r_rptr;
  logic [NID-1:0]  r_busy;
  logic [ID_W:0]   r_outstanding;
  logic            r_release;
  logic [ID_W-1:0] r_release_id;
  logic            r_err;

  logic            w_empty;
  logic            w_full;
  logic            w_ready;
  logic            w_conflict;
  logic            w_accept;
  logic            w_pop;
  logic            w_cpl_ok;
  logic            w_cpl_bad;
  beat_t           w_head;
  beat_t           w_in;
  logic [NID-1:0]  w_busy_nxt;

  // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) &&
                      (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_ready    = !w_full && (r_outstanding < MAX_OUT_V);
  // Uses pre-edge busy, so a same-cycle completion of id_c does not unblock it.
  assign w_conflict = bus.valid_c && r_busy[bus.id_c];
  assign w_accept   = bus.valid_c && w_ready && !w_conflict;
  assign w_pop      = !w_empty && bus.m_ready;
  assign w_cpl_ok   = bus.cpl_valid &&  r_busy[bus.cpl_id];
  assign w_cpl_bad  = bus.cpl_valid && !r_busy[bus.cpl_id];
  assign w_head     = r_mem[r_rptr[PW-1:0]];
  assign w_in       = '{payload: bus.payload_c, id: bus.id_c, qos: bus.qos_c};

  // Busy-vector next state: completion clears, accept sets. They never hit
  // the same id in one cycle because an accepted id must not be busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_cpl_ok) w_busy_nxt[bus.cpl_id] = 1'b0;
    if (w_accept) w_busy_nxt[bus.id_c]   = 1'b1;
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr[PW-1:0]] <= w_in;
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)    r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Scoreboard busy bits.
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Outstanding count; accept is gated by credit and a valid completion
  // implies a busy entry, so the counter cannot wrap either way.
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_outstanding <= '0;
    else if (w_accept && !w_cpl_ok)   r_outstanding <= r_outstanding + CNT_ONE;
    else if (!w_accept && w_cpl_ok)   r_outstanding <= r_outstanding - CNT_ONE;
  end

  // Release pulse one cycle after a valid completion; id holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_release    <= 1'b0;
      r_release_id <= '0;
    end else begin
      r_release <= w_cpl_ok;
      if (w_cpl_ok) r_release_id <= bus.cpl_id;
    end
  end

  // Sticky flag for completions of ids that were not in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_cpl_bad) r_err <= 1'b1;
  end

  assign bus.ready_c      = w_ready;
  assign bus.conflict_c   = w_conflict;
  assign bus.release_c    = r_release;
  assign bus.releaseid_c  = r_release_id;
  assign bus.m_valid      = !w_empty;
  assign bus.m_payload    = w_head.payload;
  assign bus.m_id         = w_head.id;
  assign bus.m_qos        = w_head.qos;
  assign bus.outstanding  = r_outstanding;
  assign bus.err_spurious = r_err;
endmodule

// File: tb/tb_enigma_conflict_tracker.sv
// Bench for enigma_conflict_tracker: vector table, hand-written corner
// sequences, and a randomized run against a queue/array reference model.
// Two instances: default credit (32) and a credit-limited one (MAX_OUT=2).
module tb_enigma_conflict_tracker;
  localparam int DATA_W = 128;
  localparam int ID_W   = 6;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  enigma_conflict_tracker_if #(.DATA_W(DATA_W), .ID_W(ID_W)) a ();
  enigma_conflict_tracker_if #(.DATA_W(DATA_W), .ID_W(ID_W)) b ();

  enigma_conflict_tracker #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .MAX_OUT(32))
    u_dut  (.clk(clk), .rst_n(rst_n), .bus(a));
  enigma_conflict_tracker #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .MAX_OUT(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Same stimulus to both instances; settles combinational outputs before return.
  task automatic drv(input logic v, input logic [5:0] id, input logic [1:0] q,
                     input logic [127:0] p, input logic mr, input logic cv,
                     input logic [5:0] cid);
    a.valid_c = v;  a.id_c = id; a.qos_c = q; a.payload_c = p;
    a.m_ready = mr; a.cpl_valid = cv; a.cpl_id = cid;
    b.valid_c = v;  b.id_c = id; b.qos_c = q; b.payload_c = p;
    b.m_ready = mr; b.cpl_valid = cv; b.cpl_id = cid;
    #1;
  endtask

  task automatic idle(input logic mr);
    drv(1'b0, 6'd0, 2'd0, '0, mr, 1'b0, 6'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       v;  logic [5:0] id; logic mr; logic cv; logic [5:0] cid;
    logic       e_rdy; logic e_conf; logic e_mv; logic [5:0] e_mid;
    logic       e_rel; logic [5:0] e_relid; logic [6:0] e_out; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [5:0] id, input logic mr,
                              input logic cv, input logic [5:0] cid,
                              input logic rdy, input logic conf, input logic mv,
                              input logic [5:0] mid, input logic rel,
                              input logic [5:0] relid, input logic [6:0] outs,
                              input logic err);
    vec_t r;
    r.v = v; r.id = id; r.mr = mr; r.cv = cv; r.cid = cid;
    r.e_rdy = rdy; r.e_conf = conf; r.e_mv = mv; r.e_mid = mid;
    r.e_rel = rel; r.e_relid = relid; r.e_out = outs; r.e_err = err;
    return r;
  endfunction

  // Reference model state for the randomized run.
  typedef struct { logic [127:0] p; logic [5:0] id; logic [1:0] q; } beat_t;
  beat_t      mq[$];
  bit         mbusy[64];
  bit         merr;
  logic [5:0] mrelid;

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  initial begin : main
    vec_t         tbl[15];
    logic [127:0] pa5;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    pa5    = {16{8'hA5}};

    // Reset state
    idle(1'b0);
    tick();
    do_reset();
    chk("rst ready_c",     a.ready_c,      1'b1);
    chk("rst conflict_c",  a.conflict_c,   1'b0);
    chk("rst m_valid",     a.m_valid,      1'b0);
    chk("rst release_c",   a.release_c,    1'b0);
    chk("rst releaseid_c", a.releaseid_c,  6'd0);
    chk("rst outstanding", a.outstanding,  7'd0);
    chk("rst err",         a.err_spurious, 1'b0);

    // Vector table: basic flow, conflict vs same-cycle completion, spurious
    // completion, accept of one id with completion of another.
    //             v  id  mr cv cid | rdy cf mv mid | rel relid out err
    tbl[0]  = mk(1, 5, 1, 0, 0,    1, 0, 0, 0,    0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0,    1, 0, 1, 5,    0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 1, 1, 5,    1, 0, 0, 0,    1, 5, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0,    1, 0, 0, 0,    0, 5, 0, 0);
    tbl[4]  = mk(1, 9, 0, 0, 0,    1, 0, 0, 0,    0, 5, 1, 0);
    tbl[5]  = mk(1, 9, 0, 1, 9,    1, 1, 1, 9,    1, 9, 0, 0);
    tbl[6]  = mk(1, 9, 0, 0, 0,    1, 0, 1, 9,    0, 9, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0,    1, 0, 1, 9,    0, 9, 1, 0);
    tbl[8]  = mk(0, 0, 1, 1, 9,    1, 0, 1, 9,    1, 9, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 33,   1, 0, 0, 0,    0, 9, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 0,    1, 0, 0, 0,    0, 9, 0, 1);
    tbl[11] = mk(1, 7, 0, 0, 0,    1, 0, 0, 0,    0, 9, 1, 1);
    tbl[12] = mk(1, 8, 0, 1, 7,    1, 0, 1, 7,    1, 7, 1, 1);
    tbl[13] = mk(1, 8, 0, 0, 0,    1, 1, 1, 7,    0, 7, 1, 1);
    tbl[14] = mk(1, 7, 0, 0, 0,    1, 0, 1, 7,    0, 7, 2, 1);
    for (int i = 0; i < 15; i++) begin
      drv(tbl[i].v, tbl[i].id, 2'd2, pa5, tbl[i].mr, tbl[i].cv, tbl[i].cid);
      chk($sformatf("vec%0d ready_c", i),    a.ready_c,    tbl[i].e_rdy);
      chk($sformatf("vec%0d conflict_c", i), a.conflict_c, tbl[i].e_conf);
      chk($sformatf("vec%0d m_valid", i),    a.m_valid,    tbl[i].e_mv);
      if (tbl[i].e_mv) begin
        chk($sformatf("vec%0d m_id", i),      a.m_id,      tbl[i].e_mid);
        chk($sformatf("vec%0d m_qos", i),     a.m_qos,     2'd2);
        chk($sformatf("vec%0d m_payload", i), a.m_payload, pa5);
      end
      tick();
      chk($sformatf("vec%0d release_c", i),   a.release_c,    tbl[i].e_rel);
      chk($sformatf("vec%0d releaseid_c", i), a.releaseid_c,  tbl[i].e_relid);
      chk($sformatf("vec%0d outstanding", i), a.outstanding,  tbl[i].e_out);
      chk($sformatf("vec%0d err", i),         a.err_spurious, tbl[i].e_err);
    end

    // FIFO full: fill, blocked offer while popping, push+pop together, drain order.
    do_reset();
    chk("full err cleared", a.err_spurious, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 6'(i), 2'd1, 128'(i), 1'b0, 1'b0, 6'd0);
      chk($sformatf("full ready before %0d", i), a.ready_c, 1'b1);
      tick();
    end
    drv(1'b1, 6'd4, 2'd1, 128'd4, 1'b1, 1'b0, 6'd0);
    chk("full ready_c",  a.ready_c, 1'b0);
    chk("full head id0", a.m_id,    6'd0);
    tick();
    chk("full pop head id1",   a.m_id,        6'd1);
    chk("full ready after pop", a.ready_c,    1'b1);
    chk("full outstanding 4",  a.outstanding, 7'd4);
    tick();
    chk("pushpop head id2",  a.m_id,        6'd2);
    chk("pushpop ready_c",   a.ready_c,     1'b1);
    chk("pushpop outstanding", a.outstanding, 7'd5);
    for (int e = 2; e <= 4; e++) begin
      idle(1'b1);
      chk($sformatf("drain m_valid %0d", e), a.m_valid, 1'b1);
      chk($sformatf("drain m_id %0d", e),    a.m_id,    6'(e));
      chk($sformatf("drain payload %0d", e), a.m_payload, 128'(e));
      tick();
    end
    chk("drain empty", a.m_valid, 1'b0);

    // Reset mid-operation, with a completion arriving in the reset cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 6'(i), 2'd0, 128'(i), 1'b0, 1'b0, 6'd0);
      tick();
    end
    chk("midrst pre outstanding", a.outstanding, 7'd3);
    drv(1'b0, 6'd0, 2'd0, '0, 1'b0, 1'b1, 6'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(1'b0);
    chk("midrst m_valid",     a.m_valid,     1'b0);
    chk("midrst outstanding", a.outstanding, 7'd0);
    chk("midrst release_c",   a.release_c,   1'b0);
    drv(1'b1, 6'd0, 2'd0, '0, 1'b0, 1'b0, 6'd0);
    chk("midrst conflict id0", a.conflict_c, 1'b0);
    chk("midrst ready_c",      a.ready_c,    1'b1);

    // Credit limit on the MAX_OUT=2 instance.
    do_reset();
    drv(1'b1, 6'd1, 2'd0, '0, 1'b1, 1'b0, 6'd0);
    chk("credit ready id1", b.ready_c, 1'b1);
    tick();
    drv(1'b1, 6'd2, 2'd0, '0, 1'b1, 1'b0, 6'd0);
    chk("credit ready id2", b.ready_c, 1'b1);
    chk("credit head id1",  b.m_id,    6'd1);
    tick();
    idle(1'b1);
    chk("credit head id2",   b.m_id,    6'd2);
    chk("credit ready full", b.ready_c, 1'b0);
    tick();
    chk("credit fifo empty",  b.m_valid,     1'b0);
    chk("credit ready empty", b.ready_c,     1'b0);
    chk("credit outstanding", b.outstanding, 7'd2);
    drv(1'b0, 6'd0, 2'd0, '0, 1'b1, 1'b1, 6'd1);
    chk("credit ready at cpl", b.ready_c, 1'b0);
    tick();
    chk("credit ready back",  b.ready_c,     1'b1);
    chk("credit release_c",   b.release_c,   1'b1);
    chk("credit releaseid_c", b.releaseid_c, 6'd1);
    chk("credit outstanding 1", b.outstanding, 7'd1);

    // Randomized run against the reference model.
    do_reset();
    mq.delete();
    for (int i = 0; i < 64; i++) mbusy[i] = 1'b0;
    merr   = 1'b0;
    mrelid = 6'd0;
    for (int n = 0; n < 3000; n++) begin
      logic v, mr, cv, e_rdy, e_conf, e_mv, acc, ok;
      logic [5:0] id, cid;
      logic [1:0] q;
      logic [127:0] p;
      beat_t hd;
      v   = 1'($urandom_range(0, 1));
      id  = 6'($urandom_range(0, 7));
      q   = 2'($urandom_range(0, 3));
      p   = {$urandom, $urandom, $urandom, $urandom};
      mr  = ($urandom_range(0, 9) < 6);
      cv  = ($urandom_range(0, 9) < 3);
      cid = 6'($urandom_range(0, 8));
      drv(v, id, q, p, mr, cv, cid);
      e_rdy  = (mq.size() < DEPTH) && (mcount() < 32);
      e_conf = v && mbusy[id];
      e_mv   = (mq.size() != 0);
      chk("rnd ready_c",    a.ready_c,    e_rdy);
      chk("rnd conflict_c", a.conflict_c, e_conf);
      chk("rnd m_valid",    a.m_valid,    e_mv);
      if (e_mv) begin
        hd = mq[0];
        chk("rnd m_id",      a.m_id,      hd.id);
        chk("rnd m_qos",     a.m_qos,     hd.q);
        chk("rnd m_payload", a.m_payload, hd.p);
      end
      acc = v && e_rdy && !e_conf;
      ok  = cv && mbusy[cid];
      if (e_mv && mr) hd = mq.pop_front();
      if (acc) mq.push_back('{p: p, id: id, q: q});
      if (ok) begin
        mbusy[cid] = 1'b0;
        mrelid     = cid;
      end else if (cv) begin
        merr = 1'b1;
      end
      if (acc) mbusy[id] = 1'b1;
      tick();
      chk("rnd release_c",   a.release_c,    ok);
      chk("rnd releaseid_c", a.releaseid_c,  mrelid);
      chk("rnd outstanding", a.outstanding,  7'(mcount()));
      chk("rnd err",         a.err_spurious, merr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
